load_queue_mc: RTL and testbench
================================

# load_queue_mc

Parametrised multi-ID burst load queue between the SpMV datapath and the memory read port, single clock domain. Accepts stream-ID requests; for each, issues a fixed-length burst of beat addresses from a per-ID base and running beat counter. Returns in-order read data through a credit-protected buffer with valid/ready handshake, tagged with its ID and a last-beat marker. Generalises the earlier single-mode queue with configurable burst length, buffer depth, beat size, per-ID counter clear, data tagging and overflow detection.

## Interface
- DATA_WIDTH, 512, beat width in bits
- ADDR_WIDTH, 32, memory address width
- IDS_NUM, 128, number of stream IDs (power of two); ID_W = clog2(IDS_NUM)
- BASE_ADDR_WIDTH, 20, per-ID base field width
- REGION_SHIFT, 12, base is left-shifted by this amount
- BEAT_LOG2, 6, log2 bytes per beat
- CNT_WIDTH, 27, per-ID beat counter width
- BURST_LEN, 32, beats per request (power of two, ≤ 2^DQ_LOG2)
- RQ_LOG2, 4, log2 request FIFO depth
- DQ_LOG2, 8, log2 data buffer depth
- sys_clk  in  1  clock
- sys_rstn  in  1  asynchronous active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_id  in  ID_W  stream ID to load
- addr_base  in  BASE_ADDR_WIDTH*IDS_NUM  per-ID bases, ID i at [i*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH], quasi-static
- clr_valid / clr_ready  in / out  1  counter-clear handshake
- clr_id  in  ID_W  ID whose beat counter is zeroed
- mem_addr_valid / mem_addr_ready  out / in  1  address handshake
- mem_addr  out  ADDR_WIDTH  beat address
- mem_data_valid  in  1  read beat return, no backpressure, in issue order
- mem_data  in  DATA_WIDTH  read beat
- data_valid / data_ready  out / in  1  output handshake
- data  out  DATA_WIDTH  output beat
- data_id  out  ID_W  ID of output beat
- data_last  out  1  final beat of a burst
- err_overflow  out  1  sticky protocol error

## Operation
- Request FIFO (2^RQ_LOG2 entries of ID); req_ready = ~full; push on req_valid & req_ready.
- Issue FSM, states IDLE and ISSUE. Dispatch condition: request FIFO non-empty and credits ≥ BURST_LEN. Dispatch pops the FIFO, latches cur_id, zeroes beat_idx, pushes cur_id into tag FIFO, credits −= BURST_LEN.
- IDLE → ISSUE on dispatch. In ISSUE mem_addr_valid = 1; each accept (valid & ready) increments cnt[cur_id] (mod 2^CNT_WIDTH) and beat_idx. On accept with beat_idx = BURST_LEN−1: dispatch again if condition holds (stay ISSUE, no bubble), else → IDLE.
- mem_addr = ({base[cur_id], REGION_SHIFT zeros} + (cnt[cur_id] << BEAT_LOG2)) truncated to ADDR_WIDTH.
- Credits start at 2^DQ_LOG2; +1 per output pop (data_valid & data_ready); both updates apply in the same cycle. Width DQ_LOG2+1. Guarantees the data buffer never overflows.
- Tag FIFO depth 2^DQ_LOG2 / BURST_LEN entries.
- Data buffer: first-word-fall-through, 2^DQ_LOG2 entries; push on mem_data_valid. data_valid = ~empty; data/data_id = buffer head / tag head. Output beat counter; data_last = (count = BURST_LEN−1); pop tag FIFO on popped last beat.
- clr_ready = (state = IDLE); accepted clear zeroes cnt[clr_id] next cycle. Never concurrent with an increment.
- err_overflow set on mem_data_valid with buffer full, or when the count of returned beats exceeds the count of issued beats; cleared only by reset.

## Timing
- Reset: state IDLE, mem_addr_valid 0, data_valid 0, data_last 0, data_id 0, err_overflow 0, req_ready 1, clr_ready 1, all counters 0, credits 2^DQ_LOG2, FIFOs empty.
- Request pushed at cycle t → earliest mem_addr_valid at t+2 (FIFO write t+1, dispatch registered).
- Burst of BURST_LEN beats with mem_addr_ready held high: BURST_LEN consecutive cycles. Back-to-back bursts produce no gap.
- mem_data_valid at t → data_valid at t+1 if buffer was empty.
- mem_addr held stable while mem_addr_valid & ~mem_addr_ready.
- Reset mid-burst: everything returns to reset values immediately; in-flight returns after reset are the integrator's responsibility; err_overflow flags them.

## Test plan
- Base[3]=0x00010, one request ID 3, ready high → 32 addresses 0x10000..0x107C0 step 0x40 back-to-back, cnt[3]=32; second request → 0x10800 onward.
- 9 requests, memory returns immediately, data_ready low → exactly 8 bursts issued (credits 0); one data pop still blocked (<32); after 32 pops the 9th burst issues.
- Interleave IDs 1, 2, 1 → three bursts; output beats tagged 1, 2, 1; data_last asserted on beats 31, 63, 95 only.
- mem_addr_ready toggled randomly → no address skipped or duplicated; mem_addr stable while stalled.
- clr on ID 1 during ISSUE → clr_ready low until IDLE; after clear, next ID 1 burst restarts at base.
- Inject mem_data_valid with no burst outstanding → err_overflow = 1 next cycle and stays 1 until sys_rstn low.

Source files
------------

// File: rtl/load_queue_mc_if.sv
// Bundle of the load queue's request, clear, memory and output handshakes.
// The slave modport faces the queue; the master modport faces the datapath/memory side.
interface load_queue_mc_if #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int IDS_NUM         = 128,
    parameter int BASE_ADDR_WIDTH = 20
);
    localparam int ID_W = $clog2(IDS_NUM);

    logic                               req_valid;
    logic                               req_ready;
    logic [ID_W-1:0]                    req_id;
    logic [BASE_ADDR_WIDTH*IDS_NUM-1:0] addr_base;
    logic                               clr_valid;
    logic                               clr_ready;
    logic [ID_W-1:0]                    clr_id;
    logic                               mem_addr_valid;
    logic                               mem_addr_ready;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic                               mem_data_valid;
    logic [DATA_WIDTH-1:0]              mem_data;
    logic                               data_valid;
    logic                               data_ready;
    logic [DATA_WIDTH-1:0]              data;
    logic [ID_W-1:0]                    data_id;
    logic                               data_last;
    logic                               err_overflow;

    modport slave (
        input  req_valid, req_id, addr_base, clr_valid, clr_id,
               mem_addr_ready, mem_data_valid, mem_data, data_ready,
        output req_ready, clr_ready, mem_addr_valid, mem_addr,
               data_valid, data, data_id, data_last, err_overflow
    );

    modport master (
        output req_valid, req_id, addr_base, clr_valid, clr_id,
               mem_addr_ready, mem_data_valid, mem_data, data_ready,
        input  req_ready, clr_ready, mem_addr_valid, mem_addr,
               data_valid, data, data_id, data_last, err_overflow
    );
endinterface

// File: rtl/load_queue_mc.sv
// Multi-ID burst load queue: turns stream-ID requests into fixed-length beat-address bursts
// and returns in-order read data, tagged by ID, through a credit-protected FWFT buffer.
module load_queue_mc #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int IDS_NUM         = 128,
    parameter int BASE_ADDR_WIDTH = 20,
    parameter int REGION_SHIFT    = 12,
    parameter int BEAT_LOG2       = 6,
    parameter int CNT_WIDTH       = 27,
    parameter int BURST_LEN       = 32,
    parameter int RQ_LOG2         = 4,
    parameter int DQ_LOG2         = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rstn,
    load_queue_mc_if.slave  bus
);
    localparam int ID_W     = $clog2(IDS_NUM);
    localparam int RQ_DEPTH = 1 << RQ_LOG2;
    localparam int DQ_DEPTH = 1 << DQ_LOG2;
    localparam int BL_LOG2  = $clog2(BURST_LEN);
    localparam int BI_W     = (BL_LOG2 > 0) ? BL_LOG2 : 1;
    localparam int TQ_DEPTH = DQ_DEPTH / BURST_LEN;
    localparam int TQ_LOG2  = DQ_LOG2 - BL_LOG2;
    localparam int TQ_IW    = (TQ_LOG2 > 0) ? TQ_LOG2 : 1;
    localparam int CR_W     = DQ_LOG2 + 1;
    localparam int OS_W     = DQ_LOG2 + 2;

    localparam logic [CR_W-1:0] CR_INIT   = CR_W'(DQ_DEPTH);
    localparam logic [CR_W-1:0] CR_BURST  = CR_W'(BURST_LEN);
    localparam logic [BI_W-1:0] BEAT_LAST = BI_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic logic [TQ_IW-1:0] tq_next(input logic [TQ_IW-1:0] p);
        return (p == TQ_IW'(TQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                 state;
    logic [ID_W-1:0]        cur_id;
    logic [BI_W-1:0]        beat_idx;
    logic                   addr_vld;
    logic [CR_W-1:0]        credits;
    logic [CNT_WIDTH-1:0]   cnt [IDS_NUM];

    logic [ID_W-1:0]        rq_mem [RQ_DEPTH];
    logic [RQ_LOG2:0]       rq_wr, rq_rd;
    logic                   rq_empty, rq_full, rq_push;
    logic [ID_W-1:0]        rq_head;

    logic [ID_W-1:0]        tq_mem [TQ_DEPTH];
    logic [TQ_IW-1:0]       tq_wr, tq_rd;

    logic [DATA_WIDTH-1:0]  dq_mem [DQ_DEPTH];
    logic [DQ_LOG2:0]       dq_wr, dq_rd;
    logic                   dq_empty, dq_full, dq_push;
    logic [BI_W-1:0]        out_beat;
    logic [OS_W-1:0]        os_cnt;

    logic                   addr_acc, burst_end, can_dispatch, dispatch;
    logic                   out_pop, clr_fire, stray, ret_ok;
    logic [BASE_ADDR_WIDTH-1:0] cur_base;

    // Request FIFO and dispatch decision
    assign rq_empty = (rq_wr == rq_rd);
    assign rq_full  = (rq_wr[RQ_LOG2] != rq_rd[RQ_LOG2]) &&
                      (rq_wr[RQ_LOG2-1:0] == rq_rd[RQ_LOG2-1:0]);
    assign rq_push  = bus.req_valid & ~rq_full;
    assign rq_head  = rq_mem[rq_rd[RQ_LOG2-1:0]];
    assign bus.req_ready = ~rq_full;

    assign addr_acc     = addr_vld & bus.mem_addr_ready;
    assign burst_end    = addr_acc & (beat_idx == BEAT_LAST);
    assign can_dispatch = ~rq_empty & (credits >= CR_BURST);
    assign dispatch     = can_dispatch & ((state == IDLE) | burst_end);

    assign bus.clr_ready = (state == IDLE);
    assign clr_fire      = bus.clr_valid & (state == IDLE);

    assign cur_base          = bus.addr_base[cur_id*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH];
    assign bus.mem_addr      = (ADDR_WIDTH'(cur_base) << REGION_SHIFT) +
                               (ADDR_WIDTH'(cnt[cur_id]) << BEAT_LOG2);
    assign bus.mem_addr_valid = addr_vld;

    always_ff @(posedge sys_clk) begin
        if (rq_push) rq_mem[rq_wr[RQ_LOG2-1:0]] <= bus.req_id;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rq_wr <= '0;
            rq_rd <= '0;
        end else begin
            if (rq_push)  rq_wr <= rq_wr + 1'b1;
            if (dispatch) rq_rd <= rq_rd + 1'b1;
        end
    end

    // Issue FSM: back-to-back bursts chain without a bubble on the last beat
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state    <= IDLE;
            addr_vld <= 1'b0;
            cur_id   <= '0;
            beat_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state    <= ISSUE;
                        addr_vld <= 1'b1;
                        cur_id   <= rq_head;
                        beat_idx <= '0;
                    end
                end
                ISSUE: begin
                    if (burst_end) begin
                        if (dispatch) begin
                            cur_id   <= rq_head;
                            beat_idx <= '0;
                        end else begin
                            state    <= IDLE;
                            addr_vld <= 1'b0;
                        end
                    end else if (addr_acc) begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    addr_vld <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int i = 0; i < IDS_NUM; i++) cnt[i] <= '0;
        end else if (addr_acc) begin
            cnt[cur_id] <= cnt[cur_id] + 1'b1;
        end else if (clr_fire) begin
            cnt[bus.clr_id] <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) credits <= CR_INIT;
        else           credits <= credits - (dispatch ? CR_BURST : '0) + CR_W'(out_pop);
    end

    // Return path: tag FIFO, data buffer and output beat counter
    assign out_pop  = bus.data_valid & bus.data_ready;
    assign dq_empty = (dq_wr == dq_rd);
    assign dq_full  = (dq_wr[DQ_LOG2] != dq_rd[DQ_LOG2]) &&
                      (dq_wr[DQ_LOG2-1:0] == dq_rd[DQ_LOG2-1:0]);
    // A return with nothing outstanding is flagged and dropped so it cannot pick up a stale tag.
    assign stray    = bus.mem_data_valid & (os_cnt == '0) & ~addr_acc;
    assign ret_ok   = bus.mem_data_valid & ~stray;
    assign dq_push  = ret_ok & ~dq_full;

    assign bus.data_valid = ~dq_empty;
    assign bus.data       = dq_mem[dq_rd[DQ_LOG2-1:0]];
    assign bus.data_id    = bus.data_valid ? tq_mem[tq_rd] : '0;
    assign bus.data_last  = bus.data_valid & (out_beat == BEAT_LAST);

    always_ff @(posedge sys_clk) begin
        if (dispatch) tq_mem[tq_wr] <= rq_head;
        if (dq_push)  dq_mem[dq_wr[DQ_LOG2-1:0]] <= bus.mem_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tq_wr            <= '0;
            tq_rd            <= '0;
            dq_wr            <= '0;
            dq_rd            <= '0;
            out_beat         <= '0;
            os_cnt           <= '0;
            bus.err_overflow <= 1'b0;
        end else begin
            if (dispatch) tq_wr <= tq_next(tq_wr);
            if (dq_push)  dq_wr <= dq_wr + 1'b1;
            if (out_pop) begin
                dq_rd <= dq_rd + 1'b1;
                if (bus.data_last) begin
                    out_beat <= '0;
                    tq_rd    <= tq_next(tq_rd);
                end else begin
                    out_beat <= out_beat + 1'b1;
                end
            end
            os_cnt <= os_cnt + OS_W'(addr_acc) - OS_W'(ret_ok);
            if (stray | (bus.mem_data_valid & dq_full)) bus.err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_load_queue_mc.sv
// Scoreboard bench for load_queue_mc: requests push expected addresses and beats,
// a bus process models the memory and pops/compares on every handshake.
module tb_load_queue_mc;
    localparam int DW   = 512;
    localparam int AW   = 32;
    localparam int IDS  = 128;
    localparam int BW   = 20;
    localparam int BL   = 32;
    localparam int ID_W = 7;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    logic sys_clk  = 1'b0;
    logic sys_rstn = 1'b0;
    always #5 sys_clk = ~sys_clk;

    load_queue_mc_if bus ();

    load_queue_mc dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .bus      (bus)
    );

    logic [AW-1:0] exp_addr_q [$];
    beat_t         exp_data_q [$];
    logic [AW-1:0] ret_q      [$];
    logic [AW-1:0] acc_log    [$];
    int            acc_cyc    [$];
    int            last_pos   [$];
    logic [BW-1:0] base_tab   [IDS];
    logic [26:0]   tb_cnt     [IDS];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pop_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   inject = 1'b0;
    logic prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] log_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int pos_at(input int i);
        return (i < last_pos.size()) ? last_pos[i] : -1;
    endfunction

    // Memory model plus monitor: drive on the falling edge, sample just before the rising edge
    always @(negedge sys_clk) begin
        if (inject) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = '1;
        end else if (ret_q.size() > 0) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = {16{ret_q.pop_front()}};
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data       = '0;
        end
        bus.mem_addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #4;
        if (sys_rstn) begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.mem_addr_valid), 1);
                check("stall_addr", bus.mem_addr, prev_addr);
            end
            if (bus.mem_addr_valid && bus.mem_addr_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL addr_unexpected: got %0h, expected no address", bus.mem_addr);
                end else begin
                    check("addr", bus.mem_addr, exp_addr_q.pop_front());
                end
                ret_q.push_back(bus.mem_addr);
                acc_log.push_back(bus.mem_addr);
                acc_cyc.push_back(cyc);
            end
            prev_stall = bus.mem_addr_valid & ~bus.mem_addr_ready;
            prev_addr  = bus.mem_addr;
            if (bus.data_valid && bus.data_ready) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected: got word %0h id %0d, expected no beat",
                             bus.data[31:0], bus.data_id);
                end else begin
                    beat_t e;
                    e = exp_data_q.pop_front();
                    if (bus.data !== {16{e.addr}} || bus.data_id !== e.id || bus.data_last !== e.last) begin
                        errors++;
                        $display("FAIL data_beat %0d: got word %0h id %0d last %0b, expected word %0h id %0d last %0b",
                                 pop_cnt, bus.data[31:0], bus.data_id, bus.data_last, e.addr, e.id, e.last);
                    end
                end
                if (bus.data_last) last_pos.push_back(pop_cnt);
                pop_cnt++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic drive_bases();
        for (int i = 0; i < IDS; i++) bus.addr_base[i*BW +: BW] = base_tab[i];
    endtask

    task automatic do_reset();
        sys_rstn       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.clr_valid  = 1'b0;
        bus.clr_id     = '0;
        bus.data_ready = 1'b0;
        rand_ready     = 1'b0;
        inject         = 1'b0;
        drive_bases();
        repeat (3) tick();
        exp_addr_q.delete();
        exp_data_q.delete();
        ret_q.delete();
        acc_log.delete();
        acc_cyc.delete();
        last_pos.delete();
        pop_cnt = 0;
        for (int i = 0; i < IDS; i++) tb_cnt[i] = '0;
        sys_rstn = 1'b1;
        tick();
    endtask

    task automatic push_exp(input int id);
        logic [AW-1:0] a;
        for (int b = 0; b < BL; b++) begin
            a = (32'(base_tab[id]) << 12) + (32'(tb_cnt[id]) << 6);
            exp_addr_q.push_back(a);
            exp_data_q.push_back('{addr: a, id: ID_W'(id), last: (b == BL - 1)});
            tb_cnt[id] = tb_cnt[id] + 1'b1;
        end
    endtask

    task automatic send_req(input int id);
        int n;
        push_exp(id);
        bus.req_valid = 1'b1;
        bus.req_id    = ID_W'(id);
        n = 0;
        while (!bus.req_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready 0 for %0d cycles, expected 1", n);
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_addr_q.size() > 0 || exp_data_q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (exp_addr_q.size() > 0 || exp_data_q.size() > 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d addresses and %0d beats pending, expected 0",
                     name, exp_addr_q.size(), exp_data_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < IDS; i++) base_tab[i] = '0;
        base_tab[3] = 20'h00010;
        base_tab[5] = 20'h00100;
        base_tab[1] = 20'h00200;
        base_tab[2] = 20'h00300;
        base_tab[7] = 20'h00400;

        // Reset values
        do_reset();
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_clr_ready", 32'(bus.clr_ready), 1);
        check("rst_addr_valid", 32'(bus.mem_addr_valid), 0);
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_data_last", 32'(bus.data_last), 0);
        check("rst_data_id", 32'(bus.data_id), 0);
        check("rst_err", 32'(bus.err_overflow), 0);

        // Single burst on ID 3: latency, address range, back-to-back beats, continuation
        bus.data_ready = 1'b1;
        push_exp(3);
        bus.req_valid = 1'b1;
        bus.req_id    = 7'd3;
        tick();
        bus.req_valid = 1'b0;
        check("t1_lat_t1", 32'(bus.mem_addr_valid), 0);
        tick();
        check("t1_lat_t2", 32'(bus.mem_addr_valid), 1);
        wait_drain("t1a", 300);
        check("t1_count", 32'(acc_log.size()), 32);
        check("t1_first", log_at(0), 32'h0001_0000);
        check("t1_last", log_at(31), 32'h0001_07C0);
        check("t1_span", 32'((acc_cyc.size() == 32) ? acc_cyc[31] - acc_cyc[0] : -1), 31);
        send_req(3);
        wait_drain("t1b", 300);
        check("t1_second", log_at(32), 32'h0001_0800);

        // Credit limit: 9 requests with output stalled
        do_reset();
        for (int r = 0; r < 9; r++) send_req(5);
        repeat (400) tick();
        check("t2_eight_bursts", 32'(acc_log.size()), 256);
        check("t2_data_valid", 32'(bus.data_valid), 1);
        check("t2_no_err_full", 32'(bus.err_overflow), 0);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        repeat (60) tick();
        check("t2_one_pop_blocked", 32'(acc_log.size()), 256);
        bus.data_ready = 1'b1;
        repeat (31) tick();
        bus.data_ready = 1'b0;
        repeat (60) tick();
        check("t2_ninth_burst", 32'(acc_log.size()), 288);
        bus.data_ready = 1'b1;
        wait_drain("t2", 2000);

        // Interleaved IDs 1, 2, 1
        do_reset();
        bus.data_ready = 1'b1;
        send_req(1);
        send_req(2);
        send_req(1);
        wait_drain("t3", 1000);
        check("t3_count", 32'(acc_log.size()), 96);
        check("t3_span", 32'((acc_cyc.size() == 96) ? acc_cyc[95] - acc_cyc[0] : -1), 95);
        check("t3_third_start", log_at(64), 32'h0020_0800);
        check("t3_last_count", 32'(last_pos.size()), 3);
        check("t3_last0", 32'(pos_at(0)), 31);
        check("t3_last1", 32'(pos_at(1)), 63);
        check("t3_last2", 32'(pos_at(2)), 95);

        // Random address backpressure
        do_reset();
        bus.data_ready = 1'b1;
        rand_ready = 1'b1;
        send_req(7);
        send_req(7);
        wait_drain("t4", 3000);
        rand_ready = 1'b0;
        check("t4_count", 32'(acc_log.size()), 64);
        check("t4_last_addr", log_at(63), 32'h0040_0FC0);

        // Counter clear held off until the issue FSM is idle
        do_reset();
        bus.data_ready = 1'b1;
        send_req(1);
        tick();
        tick();
        check("t5_clr_busy", 32'(bus.clr_ready), 0);
        bus.clr_valid = 1'b1;
        bus.clr_id    = 7'd1;
        n = 0;
        while (!bus.clr_ready && n < 200) begin
            tick();
            n++;
        end
        check("t5_clr_wait_bounded", 32'(n < 200), 1);
        check("t5_clr_after_burst", 32'(acc_log.size()), 32);
        tick();
        bus.clr_valid = 1'b0;
        tb_cnt[1] = '0;
        send_req(1);
        wait_drain("t5", 500);
        check("t5_restart", log_at(32), 32'h0020_0000);

        // Stray return sets the sticky error until reset
        do_reset();
        check("t6_err_before", 32'(bus.err_overflow), 0);
        @(posedge sys_clk);
        inject = 1'b1;
        @(posedge sys_clk);
        inject = 1'b0;
        tick();
        check("t6_err_set", 32'(bus.err_overflow), 1);
        repeat (10) tick();
        check("t6_err_sticky", 32'(bus.err_overflow), 1);
        sys_rstn = 1'b0;
        #1;
        check("t6_err_reset", 32'(bus.err_overflow), 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
